// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline definitions: ALU op encodings, funct constants,
// multiplier FSM states and the EX/MEM control payload.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   // {funct7, funct3}
   localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
   localparam logic [9:0] FUNCT_XOR = 10'b0000000_100;
   localparam logic [9:0] FUNCT_SLL = 10'b0000000_001;
   localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
   localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
   localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;

   localparam logic [2:0] FUNCT3_ADDI = 3'b000;
   localparam logic [2:0] FUNCT3_SRAI = 3'b101;
   localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_BUSY = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic [4:0] rd;
   } ex_ctrl_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per BUSY cycle, low
// WIDTH bits of the product kept. DONE is held while hold is high.
module seq_multiplier #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEPS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hold,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   import cpu_pkg::*;

   localparam int unsigned CNT_W = $clog2(STEPS + 1);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MUL_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == MUL_IDLE && start) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
         end else if (state_q == MUL_BUSY) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
         end
      end
   end

   // busy is combinational so the front end stalls in the accepting cycle
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (start) begin
               busy    = 1'b1;
               state_d = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            busy = 1'b1;
            if (cnt_q == CNT_W'(STEPS - 1)) state_d = MUL_DONE;
         end
         MUL_DONE: begin
            done = 1'b1;
            if (!hold) state_d = MUL_IDLE;
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   assign ready   = (state_q == MUL_IDLE);
   assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: forwarding, ALU, multiplier and the EX/MEM register.
// FAST_MUL_EN selects a single-cycle combinational mul instead of the FSM.
module ex_stage #(
   parameter int unsigned XLEN       = cpu_pkg::XLEN,
   parameter int unsigned MUL_CYCLES = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            mem_stall_i,
   input  logic            RegWrite_i,
   input  logic            MemtoReg_i,
   input  logic            MemRead_i,
   input  logic            MemWrite_i,
   input  logic [1:0]      ALUOp_i,
   input  logic            ALUSrc_i,
   input  logic [XLEN-1:0] RS1data_i,
   input  logic [XLEN-1:0] RS2data_i,
   input  logic [XLEN-1:0] Imm_i,
   input  logic [9:0]      funct_i,
   input  logic [4:0]      RDaddr_i,
   input  logic [4:0]      RS1addr_i,
   input  logic [4:0]      RS2addr_i,
   input  logic            exmem_RegWrite_i,
   input  logic [4:0]      exmem_RDaddr_i,
   input  logic [XLEN-1:0] exmem_ALUResult_i,
   input  logic            memwb_RegWrite_i,
   input  logic [4:0]      memwb_RDaddr_i,
   input  logic [XLEN-1:0] memwb_WBdata_i,
   output logic            stall_o,
   output logic            RegWrite_o,
   output logic            MemtoReg_o,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic [XLEN-1:0] ALUResult_o,
   output logic [XLEN-1:0] RS2data_o,
   output logic [4:0]      RDaddr_o
);
   import cpu_pkg::*;

   logic [XLEN-1:0] rs1_fwd, rs2_fwd, opb, alu_res, ld_result;
   logic            is_mul, bubble;
   ex_ctrl_t        cur_ctrl, ld_ctrl, exmem_ctrl_q;
   logic [XLEN-1:0] exmem_alu_q, exmem_rs2_q;

   // EX/MEM has priority over MEM/WB; x0 never forwards
   always_comb begin
      rs1_fwd = RS1data_i;
      if (exmem_RegWrite_i && exmem_RDaddr_i != 5'd0 && exmem_RDaddr_i == RS1addr_i)
         rs1_fwd = exmem_ALUResult_i;
      else if (memwb_RegWrite_i && memwb_RDaddr_i != 5'd0 && memwb_RDaddr_i == RS1addr_i)
         rs1_fwd = memwb_WBdata_i;
   end

   always_comb begin
      rs2_fwd = RS2data_i;
      if (exmem_RegWrite_i && exmem_RDaddr_i != 5'd0 && exmem_RDaddr_i == RS2addr_i)
         rs2_fwd = exmem_ALUResult_i;
      else if (memwb_RegWrite_i && memwb_RDaddr_i != 5'd0 && memwb_RDaddr_i == RS2addr_i)
         rs2_fwd = memwb_WBdata_i;
   end

   assign opb      = ALUSrc_i ? Imm_i : rs2_fwd;
   assign is_mul   = (ALUOp_i == ALUOP_RTYPE) && (funct_i == FUNCT_MUL);
   assign cur_ctrl = {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, RDaddr_i};

   always_comb begin
      alu_res = '0;
      case (ALUOp_i)
         ALUOP_ADD: alu_res = rs1_fwd + opb;
         ALUOP_SUB: alu_res = rs1_fwd - opb;
         ALUOP_RTYPE: begin
            case (funct_i)
               FUNCT_AND: alu_res = rs1_fwd & opb;
               FUNCT_XOR: alu_res = rs1_fwd ^ opb;
               FUNCT_SLL: alu_res = rs1_fwd << rs2_fwd[4:0];
               FUNCT_ADD: alu_res = rs1_fwd + opb;
               FUNCT_SUB: alu_res = rs1_fwd - opb;
`ifdef FAST_MUL_EN
               FUNCT_MUL: alu_res = rs1_fwd * opb;
`endif
               default:   alu_res = '0;
            endcase
         end
         ALUOP_ITYPE: begin
            if (funct_i[2:0] == FUNCT3_ADDI)
               alu_res = rs1_fwd + opb;
            else if (funct_i[9:3] == FUNCT7_SRA && funct_i[2:0] == FUNCT3_SRAI)
               alu_res = XLEN'($signed(rs1_fwd) >>> Imm_i[4:0]);
         end
         default: alu_res = '0;
      endcase
   end

`ifdef FAST_MUL_EN
   assign bubble    = 1'b0;
   assign ld_ctrl   = cur_ctrl;
   assign ld_result = alu_res;
`else
   logic            mul_start, mul_ready, mul_busy, mul_done;
   logic [XLEN-1:0] mul_product;
   ex_ctrl_t        cap_ctrl_q;

   assign mul_start = is_mul && RegWrite_i;

   seq_multiplier #(
      .WIDTH (XLEN),
      .STEPS (MUL_CYCLES)
   ) u_mul (
      .clk     (clk_i),
      .rst     (rst_i),
      .start   (mul_start),
      .hold    (mem_stall_i),
      .a       (rs1_fwd),
      .b       (opb),
      .ready   (mul_ready),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // forwarding sources drain during the stall, so control is captured at start
   always_ff @(posedge clk_i) begin
      if (rst_i)                       cap_ctrl_q <= '0;
      else if (mul_start && mul_ready) cap_ctrl_q <= cur_ctrl;
   end

   assign bubble    = mul_busy;
   assign ld_ctrl   = mul_done ? cap_ctrl_q  : cur_ctrl;
   assign ld_result = mul_done ? mul_product : alu_res;
`endif

   assign stall_o = bubble;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         exmem_ctrl_q <= '0;
         exmem_alu_q  <= '0;
         exmem_rs2_q  <= '0;
      end else if (!mem_stall_i) begin
         if (bubble) begin
            exmem_ctrl_q <= '0;
            exmem_alu_q  <= '0;
            exmem_rs2_q  <= '0;
         end else begin
            exmem_ctrl_q <= ld_ctrl;
            exmem_alu_q  <= ld_result;
            exmem_rs2_q  <= rs2_fwd;
         end
      end
   end

   assign RegWrite_o  = exmem_ctrl_q.reg_write;
   assign MemtoReg_o  = exmem_ctrl_q.mem_to_reg;
   assign MemRead_o   = exmem_ctrl_q.mem_read;
   assign MemWrite_o  = exmem_ctrl_q.mem_write;
   assign RDaddr_o    = exmem_ctrl_q.rd;
   assign ALUResult_o = exmem_alu_q;
   assign RS2data_o   = exmem_rs2_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: transaction-level model of forwarding,
// ALU and multi-cycle mul timing, plus directed literal checks.
module tb_ex_stage;

   localparam int unsigned MULC = 32;
`ifdef FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk, rst, mem_stall;
   logic        rw_i, mtr_i, mr_i, mw_i, alusrc;
   logic [1:0]  aluop;
   logic [31:0] rs1d, rs2d, imm;
   logic [9:0]  funct;
   logic [4:0]  rd, rs1a, rs2a;
   logic        xm_rw, wb_rw;
   logic [4:0]  xm_rd, wb_rd;
   logic [31:0] xm_val, wb_val;
   logic        stall, o_rw, o_mtr, o_mr, o_mw;
   logic [31:0] o_alu, o_rs2;
   logic [4:0]  o_rd;

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;

   ex_stage dut (
      .clk_i(clk), .rst_i(rst), .mem_stall_i(mem_stall),
      .RegWrite_i(rw_i), .MemtoReg_i(mtr_i), .MemRead_i(mr_i), .MemWrite_i(mw_i),
      .ALUOp_i(aluop), .ALUSrc_i(alusrc),
      .RS1data_i(rs1d), .RS2data_i(rs2d), .Imm_i(imm), .funct_i(funct),
      .RDaddr_i(rd), .RS1addr_i(rs1a), .RS2addr_i(rs2a),
      .exmem_RegWrite_i(xm_rw), .exmem_RDaddr_i(xm_rd), .exmem_ALUResult_i(xm_val),
      .memwb_RegWrite_i(wb_rw), .memwb_RDaddr_i(wb_rd), .memwb_WBdata_i(wb_val),
      .stall_o(stall), .RegWrite_o(o_rw), .MemtoReg_o(o_mtr), .MemRead_o(o_mr),
      .MemWrite_o(o_mw), .ALUResult_o(o_alu), .RS2data_o(o_rs2), .RDaddr_o(o_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rw, mtr, mr, mw;
      logic [1:0]  aluop;
      logic        alusrc;
      logic [31:0] rs1d, rs2d, imm;
      logic [9:0]  funct;
      logic [4:0]  rd, rs1, rs2;
   } instr_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] e_alu, e_rs2, m_prod;
   logic [4:0]  e_rd, m_rd;
   logic [3:0]  e_ctl, m_ctl;
   bit          pend, accepted, valid;
   int          wcnt;

   function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
      if (xm_rw && xm_rd != 5'd0 && xm_rd == a) return xm_val;
      if (wb_rw && wb_rd != 5'd0 && wb_rd == a) return wb_val;
      return d;
   endfunction

   function automatic logic [31:0] ref_alu();
      logic [31:0] a, r2, b;
      a  = fwd(rs1a, rs1d);
      r2 = fwd(rs2a, rs2d);
      b  = alusrc ? imm : r2;
      case (aluop)
         2'b00: return a + b;
         2'b01: return a - b;
         2'b10: begin
            case (funct)
               10'b0000000_111: return a & b;
               10'b0000000_100: return a ^ b;
               10'b0000000_001: return a << r2[4:0];
               10'b0000000_000: return a + b;
               10'b0100000_000: return a - b;
               10'b0000001_000: return a * b;
               default:         return 32'd0;
            endcase
         end
         default: begin
            if (funct[2:0] == 3'b000) return a + b;
            if (funct == 10'b0100000_101) return 32'($signed(a) >>> imm[4:0]);
            return 32'd0;
         end
      endcase
   endfunction

   function automatic bit mul_req();
      return !FAST && rw_i && aluop == 2'b10 && funct == 10'b0000001_000;
   endfunction

   function automatic bit exp_stall();
      return pend ? (wcnt > 0) : mul_req();
   endfunction

   always @(posedge clk) begin
      bit st;
      if (rst) begin
         e_alu = '0; e_rs2 = '0; e_rd = '0; e_ctl = '0;
         pend = 0; wcnt = 0; accepted = 0; valid = 1;
      end else begin
         st = exp_stall();
         accepted = !mem_stall && !st;
         if (!pend && mul_req()) begin
            pend   = 1;
            wcnt   = MULC;
            m_prod = ref_alu();
            m_rd   = rd;
            m_ctl  = {rw_i, mtr_i, mr_i, mw_i};
         end else if (pend && wcnt > 0) begin
            wcnt--;
         end
         if (!mem_stall) begin
            if (st) begin
               e_alu = '0; e_rs2 = '0; e_rd = '0; e_ctl = '0;
            end else if (pend) begin
               e_alu = m_prod; e_rd = m_rd; e_ctl = m_ctl; e_rs2 = fwd(rs2a, rs2d);
               pend = 0;
            end else begin
               e_alu = ref_alu(); e_rd = rd; e_ctl = {rw_i, mtr_i, mr_i, mw_i};
               e_rs2 = fwd(rs2a, rs2d);
            end
         end
      end
   end

   // compare process
   always @(negedge clk) begin
      if (stall === 1'b1) stall_cnt++;
      if (valid) begin
         if (!rst) chk("stall", 32'(stall), 32'(exp_stall()));
         chk("alu_result", o_alu, e_alu);
         chk("rs2_data", o_rs2, e_rs2);
         chk("rd_addr", 32'(o_rd), 32'(e_rd));
         chk("ctrl", 32'({o_rw, o_mtr, o_mr, o_mw}), 32'(e_ctl));
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input instr_t i);
      rw_i = i.rw; mtr_i = i.mtr; mr_i = i.mr; mw_i = i.mw;
      aluop = i.aluop; alusrc = i.alusrc; rs1d = i.rs1d; rs2d = i.rs2d;
      imm = i.imm; funct = i.funct; rd = i.rd; rs1a = i.rs1; rs2a = i.rs2;
   endtask

   function automatic instr_t mk(input logic [1:0] op, input logic [9:0] f, input logic src,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                 input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
      instr_t i;
      i = '0;
      i.rw = 1'b1; i.aluop = op; i.funct = f; i.alusrc = src;
      i.rs1d = a; i.rs2d = b; i.imm = im; i.rd = d; i.rs1 = s1; i.rs2 = s2;
      return i;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t i;
      int k;
      i.rw = 1'($urandom_range(0, 1)); i.mtr = 1'($urandom_range(0, 1));
      i.mr = 1'($urandom_range(0, 1)); i.mw = 1'($urandom_range(0, 1));
      i.aluop = 2'($urandom_range(0, 3)); i.alusrc = 1'($urandom_range(0, 1));
      i.rs1d = $urandom; i.rs2d = $urandom; i.imm = $urandom;
      i.rd = 5'($urandom_range(0, 7)); i.rs1 = 5'($urandom_range(0, 7));
      i.rs2 = 5'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      case (k)
         0: i.funct = 10'b0000000_111;
         1: i.funct = 10'b0000000_100;
         2: i.funct = 10'b0000000_001;
         3: i.funct = 10'b0000000_000;
         4: i.funct = 10'b0100000_000;
         5: begin i.funct = 10'b0000001_000; i.aluop = 2'b10; end
         6: i.funct = 10'b0100000_101;
         7: i.funct = {7'($urandom), 3'b000};
         default: i.funct = 10'($urandom);
      endcase
      if (i.aluop == 2'b10 && i.funct == 10'b0000001_000) i.rw = 1'b1;
      return i;
   endfunction

   task automatic issue(input instr_t i, input bit rnd, output int edges);
      present(i);
      edges = 0;
      for (int n = 0; n < 200; n++) begin
         if (rnd) begin
            xm_rw = 1'($urandom_range(0, 1)); xm_rd = 5'($urandom_range(0, 7)); xm_val = $urandom;
            wb_rw = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_val = $urandom;
            mem_stall = ($urandom_range(0, 6) == 0);
         end
         tick();
         edges++;
         if (accepted) return;
      end
      checks++; errors++;
      $display("FAIL issue_timeout got %0d edges expected acceptance", edges);
   endtask

   initial begin
      int e;
      int n;
      rst = 1'b1; mem_stall = 1'b0;
      present('0);
      xm_rw = 0; xm_rd = 0; xm_val = 0; wb_rw = 0; wb_rd = 0; wb_val = 0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_alu", o_alu, 32'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_regwrite", 32'(o_rw), 32'd0);

      // EX/MEM wins over MEM/WB for x3
      xm_rw = 1; xm_rd = 5'd3; xm_val = 32'h10;
      wb_rw = 1; wb_rd = 5'd3; wb_val = 32'h20;
      issue(mk(2'b10, 10'b0000000_000, 1'b0, 32'd5, 32'd7, 32'd0, 5'd5, 5'd3, 5'd4), 0, e);
      chk("fwd_priority", o_alu, 32'h17);

      // x0 is never forwarded
      xm_rw = 1; xm_rd = 5'd0; xm_val = 32'hFF; wb_rw = 0;
      issue(mk(2'b10, 10'b0000000_000, 1'b0, 32'd0, 32'd1, 32'd0, 5'd5, 5'd0, 5'd2), 0, e);
      chk("fwd_x0", o_alu, 32'd1);

      xm_rw = 0; wb_rw = 0;
      stall_cnt = 0;
      issue(mk(2'b10, 10'b0000001_000, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0, 5'd6, 5'd1, 5'd2), 0, e);
      chk("mul_stall_cycles", 32'(stall_cnt), FAST ? 32'd0 : 32'd33);
      chk("mul_latency", 32'(e), FAST ? 32'd1 : 32'd34);
      chk("mul_result", o_alu, 32'hFFFF_FFFD);
      chk("mul_rd", 32'(o_rd), 32'd6);

      issue(mk(2'b11, 10'b0100000_101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 5'd7, 5'd1, 5'd2), 0, e);
      chk("srai", o_alu, 32'hF800_0000);
      issue(mk(2'b10, 10'b0000000_001, 1'b0, 32'd1, 32'd31, 32'd0, 5'd7, 5'd1, 5'd2), 0, e);
      chk("sll", o_alu, 32'h8000_0000);

`ifdef FAST_MUL_EN
      stall_cnt = 0;
      issue(mk(2'b10, 10'b0000001_000, 1'b0, 32'd1234, 32'd5678, 32'd0, 5'd8, 5'd1, 5'd2), 0, e);
      chk("fast_mul_latency", 32'(e), 32'd1);
      chk("fast_mul_result", o_alu, 32'd7006652);
      chk("fast_mul_no_stall", 32'(stall_cnt), 32'd0);
`else
      // memory stall while the multiplier sits in DONE
      present(mk(2'b10, 10'b0000001_000, 1'b0, 32'd1234, 32'd5678, 32'd0, 5'd8, 5'd1, 5'd2));
      n = 0;
      while (!(pend && wcnt == 0) && n < 100) begin
         tick();
         n++;
      end
      chk("done_reached", 32'(n), 32'd33);
      mem_stall = 1'b1;
      tick(); tick(); tick();
      chk("done_hold_alu", o_alu, 32'd0);
      chk("done_hold_regwrite", 32'(o_rw), 32'd0);
      mem_stall = 1'b0;
      tick();
      chk("done_product", o_alu, 32'd7006652);
      chk("done_rd", 32'(o_rd), 32'd8);
      stall_cnt = 0;
      present(mk(2'b11, 10'b0000000_000, 1'b1, 32'd9, 32'd0, 32'd1, 5'd9, 5'd1, 5'd2));
      tick();
      chk("no_retrigger", 32'(stall_cnt), 32'd0);
      chk("after_done", o_alu, 32'd10);
`endif

      // reset while the multiplier is counting
      present(mk(2'b10, 10'b0000001_000, 1'b0, $urandom, $urandom, 32'd0, 5'd11, 5'd1, 5'd2));
      for (int k = 0; k < 11; k++) tick();
      rst = 1'b1;
      present(mk(2'b00, 10'b0, 1'b0, 32'd100, 32'd23, 32'd0, 5'd10, 5'd1, 5'd2));
      tick();
      rst = 1'b0;
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_mid_alu", o_alu, 32'd0);
      chk("rst_mid_rd", 32'(o_rd), 32'd0);
      chk("rst_mid_regwrite", 32'(o_rw), 32'd0);
      tick();
      chk("post_rst_add", o_alu, 32'd123);
      chk("post_rst_rd", 32'(o_rd), 32'd10);

      for (int k = 0; k < 400; k++) issue(rnd_instr(), 1, e);
      mem_stall = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline; sits directly downstream of the ID/EX register and consumes all of its outputs.
- Performs operand forwarding, ALU operations and an iterative 32-cycle multiplier for `mul`.
- Owns the EX/MEM pipeline register.
- Raises `stall_o` while a multiply is in flight; the hazard unit ORs it into the ID/EX and IF/ID stall inputs.

Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, iterations of the shift-add multiplier (one product bit per cycle).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- mem_stall_i  in  1  data-memory/cache stall; freezes the EX/MEM register
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control from ID/EX
- ALUOp_i  in  2  00 = add (ld/st), 01 = sub (beq), 10 = R-type, 11 = I-type
- ALUSrc_i  in  1  1 = operand B is Imm_i
- RS1data_i, RS2data_i, Imm_i  in  32 each  from ID/EX
- funct_i  in  10  {funct7, funct3}
- RDaddr_i, RS1addr_i, RS2addr_i  in  5 each
- exmem_RegWrite_i  in  1;  exmem_RDaddr_i  in  5;  exmem_ALUResult_i  in  32  forwarding source 1
- memwb_RegWrite_i  in  1;  memwb_RDaddr_i  in  5;  memwb_WBdata_i  in  32  forwarding source 2
- stall_o  out  1  multiplier busy
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1 each  EX/MEM control
- ALUResult_o  out  32
- RS2data_o  out  32  forwarded store data
- RDaddr_o  out  5

Behaviour:
- Clocking and reset: one clock, clk_i. Synchronous active-high reset rst_i. On reset:
  - all EX/MEM outputs are 0;
  - FSM goes to IDLE;
  - stall_o is 0;
  - reset mid-multiply aborts it with no result written.
- Forwarding (combinational), applied separately to rs1 and rs2:
  - If exmem_RegWrite_i and exmem_RDaddr_i != 0 and it matches the source address, use exmem_ALUResult_i.
  - Else if the same condition holds for the memwb_* inputs, use memwb_WBdata_i.
  - Else use the ID/EX data.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
- Operand B is Imm_i when ALUSrc_i = 1, else forwarded rs2.
- ALU decode:
  - ALUOp 00: add. ALUOp 01: sub.
  - ALUOp 10 by funct: 0000000_111 and; 0000000_100 xor; 0000000_001 sll by rs2[4:0]; 0000000_000 add; 0100000_000 sub; 0000001_000 mul.
  - ALUOp 11: funct3 000 addi; funct7 0100000 with funct3 101 srai by Imm[4:0] (arithmetic shift).
  - Undefined encodings produce 0.
  - Arithmetic wraps modulo 2^32. mul returns the low 32 bits.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE with a mul decoded and RegWrite_i = 1:
    - capture forwarded operands, RDaddr and control, because forwarding sources drain while the front end is stalled;
    - clear the accumulator and count;
    - assert stall_o combinationally in that same cycle;
    - go to BUSY.
  - BUSY: one shift-add step per cycle with stall_o = 1; after MUL_CYCLES steps go to DONE.
  - DONE: stall_o = 0, and the EX/MEM register loads the product with the captured control.
    - Go to IDLE on the same edge, unless mem_stall_i is high; in that case hold DONE.
  - Latency: a mul holds ID/EX for MUL_CYCLES + 1 cycles, and its result appears in EX/MEM MUL_CYCLES + 2 edges after first presentation.
  - The mul still present in ID/EX during DONE must not retrigger the FSM, because ID/EX advances on that edge.
- EX/MEM register:
  - mem_stall_i = 1: hold every output. This takes precedence over all other cases, including bubble insertion.
  - FSM in IDLE→BUSY or BUSY: load a bubble (all control bits 0, RDaddr_o 0, data 0).
  - Otherwise (IDLE with a non-mul, or DONE): load the current results, with RS2data_o taken from forwarded rs2.
- mem_stall_i has no effect on BUSY counting.

Optional Feature:
- Macro FAST_MUL_EN.
- Defined: mul computes in a single cycle combinationally, the FSM is not built, and stall_o is tied to 0.
- Undefined: iterative FSM as above.
- Results are bit-identical in both builds.

Decomposition:
- Shared package (cpu_pkg) holds:
  - ALUOp encodings;
  - funct constants (FUNCT_AND, FUNCT_XOR, FUNCT_SLL, FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT3_ADDI, FUNCT3_SRAI);
  - FSM state typedef mul_state_t;
  - XLEN.
- One natural sub-module: seq_multiplier, containing the FSM, accumulator and counter, with start/busy/done/product ports.
- Forwarding and ALU stay in ex_stage.

Test Plan:
- Forwarding: add x3 = 5 + 7 with x3 held in EX/MEM as 0x10 and in MEM/WB as 0x20; the next instruction reads x3 → EX/MEM value 0x10 is used (EX/MEM priority). A write to x0 with value 0xFF is not forwarded.
- mul 0xFFFFFFFF × 3 → ALUResult_o = 0xFFFFFFFD. stall_o is high for exactly 33 cycles. EX/MEM shows bubbles meanwhile, and the product appears on the next edge.
- srai with rs1 = 0x80000000 and Imm = 4 → 0xF8000000. sll with rs1 = 1 and rs2 = 31 → 0x80000000.
- mem_stall_i pulsed high for 3 cycles while the FSM is in DONE → EX/MEM holds; the product is written once after release and there is no retrigger.
- rst_i asserted at BUSY count 10 → next cycle stall_o = 0, all outputs 0; the following non-mul instruction flows normally.
- FAST_MUL_EN build: mul 1234 × 5678 → 7006652 with one-cycle latency, and stall_o never asserts.
